// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM states and access legality check for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } lsu_state_t;

  // Unsigned sizes exist only for loads; everything else outside B/H/W is reserved.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    illegal = 1'b0;
      F3_H:    misaligned = addr_lo[0];
      F3_W:    misaligned = |addr_lo;
      F3_BU:   illegal = we;
      F3_HU: begin
        illegal    = we;
        misaligned = addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - handshaked data-memory bus between the load/store unit and memory
interface lsu_bus_if;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable generation, store lane replication and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'h000000, shifted[7:0]};
      F3_HU:   rdata_o = {16'h0000, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit stalling the core until each bus access completes
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [2:0]       core_funct3,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic             stall,
  output logic [31:0]      rdata,
  output logic             fault,
  lsu_bus_if.master        bus
);

  localparam int             CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

  lsu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          bus_valid_q, bus_valid_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;

  logic [2:0]    sel_funct3;
  logic [1:0]    sel_addr_lo;
  logic [3:0]    align_be;
  logic [31:0]   align_wdata;
  logic [31:0]   align_rdata;

  // In IDLE the aligner formats the incoming store; afterwards it extracts the load.
  assign sel_funct3  = (state_q == S_IDLE) ? core_funct3     : funct3_q;
  assign sel_addr_lo = (state_q == S_IDLE) ? core_addr[1:0]  : addr_lo_q;

  lsu_align u_align (
    .funct3_i  (sel_funct3),
    .addr_lo_i (sel_addr_lo),
    .wdata_i   (core_wdata),
    .rdata_i   (bus.bus_rdata),
    .be_o      (align_be),
    .wdata_o   (align_wdata),
    .rdata_o   (align_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;

    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          funct3_d    = core_funct3;
          addr_lo_d   = core_addr[1:0];
          bus_we_d    = core_we;
          bus_addr_d  = {core_addr[31:2], 2'b00};
          bus_be_d    = align_be;
          bus_wdata_d = align_wdata;
          cnt_d       = '0;
          if (access_fault(core_we, core_funct3, core_addr[1:0])) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = S_REQ;
            bus_valid_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (bus.bus_ready && bus_we_q) begin
          bus_valid_d = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q == LIMIT) begin
          bus_valid_d = 1'b0;
          fault_d     = 1'b1;
          rdata_d     = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (bus.bus_ready) begin
            bus_valid_d = 1'b0;
            state_d     = S_RESP;
          end
        end
      end

      S_RESP: begin
        // Data arriving on the limit cycle still completes the access.
        if (bus.bus_rvalid) begin
          rdata_d = align_rdata;
          state_d = S_DONE;
        end else if (cnt_q == LIMIT) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        fault_d = 1'b0;
        rdata_d = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign stall         = core_req & (state_q != S_DONE);
  assign rdata         = rdata_q;
  assign fault         = fault_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a behavioural access model
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk;
  logic        reset_n;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;

  int checks;
  int failures;

  lsu_bus_if bus ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_funct3 (core_funct3),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .fault       (fault),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one access from the architectural rules and the slave's wait pattern.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] word,
                                input int rw, input int vw,
                                output logic e_fault, output logic [31:0] e_rdata,
                                output int e_done, output logic e_bus, output logic e_acc,
                                output logic [3:0] e_be, output logic [31:0] e_wdata);
    int nbytes;
    int off;
    int wait_c;
    logic bad;
    longint v;
    nbytes = 1 << f3[1:0];
    off = int'(addr[1:0]);
    bad = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]) || ((off % nbytes) != 0);
    e_be = '0;
    e_wdata = '0;
    e_rdata = '0;
    if (!bad) begin
      for (int i = 0; i < 4; i++) begin
        e_be[i] = (i >= off) && (i < off + nbytes);
        e_wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
      end
      v = longint'(word) >> (8 * off);
      v = v & ((64'sd1 << (8 * nbytes)) - 1);
      if (!f3[2] && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1)
        v = v - (64'sd1 << (8 * nbytes));
      e_rdata = we ? 32'h0 : v[31:0];
    end
    wait_c = rw + 1 + (we ? 0 : ((vw < 0) ? 1000 : vw + 1));
    if (bad) begin
      e_fault = 1'b1; e_rdata = '0; e_done = 1; e_bus = 1'b0; e_acc = 1'b0;
    end else if (wait_c > TO) begin
      e_fault = 1'b1; e_rdata = '0; e_done = 1 + TO; e_bus = 1'b1; e_acc = (rw + 1 <= TO);
    end else begin
      e_fault = 1'b0; e_done = 1 + wait_c; e_bus = 1'b1; e_acc = 1'b1;
    end
  endfunction

  // Drives one access from an IDLE cycle and plays a slave with the given wait pattern.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] word,
                            input int rw, input int vw,
                            output int done_cyc, output logic [31:0] o_rdata, output logic o_fault,
                            output logic saw_valid, output logic unstable, output logic acc,
                            output logic [31:0] acc_addr, output logic [3:0] acc_be,
                            output logic [31:0] acc_wdata, output logic acc_we,
                            output logic early_fault);
    int vcnt;
    int rcnt;
    logic in_resp;
    logic [31:0] first_addr;
    vcnt = 0; rcnt = 0; in_resp = 1'b0; first_addr = '0;
    done_cyc = -1; o_rdata = 'x; o_fault = 1'bx;
    saw_valid = 1'b0; unstable = 1'b0; acc = 1'b0; early_fault = 1'b0;
    acc_addr = '0; acc_be = '0; acc_wdata = '0; acc_we = 1'b0;
    core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = word;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall) begin
        done_cyc = c; o_rdata = rdata; o_fault = fault;
        break;
      end
      if (fault) early_fault = 1'b1;
      if (in_resp) begin
        rcnt++;
        bus.bus_rvalid = (vw >= 0) && (rcnt > vw);
      end
      if (bus.bus_valid) begin
        saw_valid = 1'b1;
        if (vcnt == 0) first_addr = bus.bus_addr;
        else if (bus.bus_addr !== first_addr) unstable = 1'b1;
        vcnt++;
        bus.bus_ready = (vcnt > rw);
        if (bus.bus_ready) begin
          acc = 1'b1; acc_addr = bus.bus_addr; acc_be = bus.bus_be;
          acc_wdata = bus.bus_wdata; acc_we = bus.bus_we;
          in_resp = !bus.bus_we;
        end
      end else begin
        bus.bus_ready = 1'b0;
      end
    end
    core_req = 1'b0; bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  int d; logic [31:0] r; logic f, sv, us, ac, aw, ef; logic [31:0] aa, ad; logic [3:0] ab;

  task automatic test_reset();
    reset_n = 1'b0; core_req = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_follow: got %b expected 1", stall); end
    core_req = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_low: got %b expected 0", stall); end
    checks++;
    if ({bus.bus_valid, bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, rdata, fault} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b we=%b be=%h addr=%h wdata=%h rdata=%h fault=%b expected all 0",
               bus.bus_valid, bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, rdata, fault);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (r !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata: got %h expected ffffff80", r); end
    checks++; if (f !== 1'b0 || d != 3) begin failures++; $display("FAIL lb_done: got fault=%b cycle=%0d expected 0/3", f, d); end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (r !== 32'h0000_0080) begin failures++; $display("FAIL lbu_rdata: got %h expected 00000080", r); end
    run_access(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (ab !== 4'b1100) begin failures++; $display("FAIL sh_be: got %b expected 1100", ab); end
    checks++; if (ad !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata: got %h expected abcdabcd", ad); end
    checks++; if (aa !== 32'h200 || aw !== 1'b1) begin failures++; $display("FAIL sh_addr: got %h we=%b expected 00000200 we=1", aa, aw); end
    checks++; if (d != 2 || f !== 1'b0) begin failures++; $display("FAIL sh_done: got cycle=%0d fault=%b expected 2/0", d, f); end
    run_access(1'b0, 3'b010, 32'h006, 32'h0, 32'h1234_5678, 0, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (d != 1 || f !== 1'b1) begin failures++; $display("FAIL lw_misalign: got cycle=%0d fault=%b expected 1/1", d, f); end
    checks++; if (sv !== 1'b0 || r !== 32'h0) begin failures++; $display("FAIL lw_misalign_bus: got valid_seen=%b rdata=%h expected 0/0", sv, r); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_pulse: got %b expected 0 after DONE", fault); end
  endtask

  task automatic test_wait_states();
    logic [31:0] w;
    w = $urandom;
    run_access(1'b0, 3'b010, 32'h300, 32'h0, w, 3, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (d != 6) begin failures++; $display("FAIL wait_done: got cycle=%0d expected 6", d); end
    checks++; if (us !== 1'b0 || aa !== 32'h300) begin failures++; $display("FAIL wait_stable: got unstable=%b addr=%h expected 0/00000300", us, aa); end
    checks++; if (r !== w || f !== 1'b0) begin failures++; $display("FAIL wait_rdata: got %h fault=%b expected %h/0", r, f, w); end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    run_access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, -1, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (d != 1 + TO || f !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL timeout: got cycle=%0d fault=%b rdata=%h expected %0d/1/0", d, f, r, 1 + TO); end
    checks++; if (fault !== 1'b0 || bus.bus_valid !== 1'b0) begin failures++; $display("FAIL timeout_idle: got fault=%b valid=%b expected 0/0", fault, bus.bus_valid); end
    w = $urandom;
    run_access(1'b0, 3'b010, 32'h14, 32'h0, w, 0, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (d != 3 || f !== 1'b0 || r !== w) begin failures++; $display("FAIL after_timeout: got cycle=%0d fault=%b rdata=%h expected 3/0/%h", d, f, r, w); end
    run_access(1'b0, 3'b010, 32'h18, 32'h0, w, 2, TO - 4, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (d != 1 + TO || f !== 1'b0 || r !== w) begin failures++; $display("FAIL rvalid_at_limit: got cycle=%0d fault=%b rdata=%h expected %0d/0/%h", d, f, r, 1 + TO, w); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h40; core_wdata = 32'h0;
    bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.bus_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.bus_valid, bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, rdata, fault} !== '0 || stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: got valid=%b be=%h addr=%h rdata=%h fault=%b stall=%b expected zeros, stall=1",
               bus.bus_valid, bus.bus_be, bus.bus_addr, rdata, fault, stall);
    end
    core_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    w = $urandom;
    run_access(1'b0, 3'b010, 32'h44, 32'h0, w, 0, 0, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
    checks++; if (d != 3 || f !== 1'b0 || r !== w) begin failures++; $display("FAIL reset_mid_lw: got cycle=%0d fault=%b rdata=%h expected 3/0/%h", d, f, r, w); end
  endtask

  task automatic test_random();
    logic we; logic [2:0] f3; logic [31:0] addr, wd, word;
    int rw, vw, e_done;
    logic e_fault, e_bus, e_acc; logic [31:0] e_rdata, e_wdata; logic [3:0] e_be;
    for (int i = 0; i < 40; i++) begin
      we = $urandom_range(0, 1); f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; word = $urandom;
      rw = $urandom_range(0, 4); vw = $urandom_range(0, 4);
      model(we, f3, addr, wd, word, rw, vw, e_fault, e_rdata, e_done, e_bus, e_acc, e_be, e_wdata);
      run_access(we, f3, addr, wd, word, rw, vw, d, r, f, sv, us, ac, aa, ab, ad, aw, ef);
      checks++;
      if (d != e_done || f !== e_fault || sv !== e_bus || us !== 1'b0 || ef !== 1'b0) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: got cycle=%0d fault=%b bus=%b unstable=%b early=%b expected %0d/%b/%b/0/0 (we=%b f3=%0d addr=%h)",
                 i, d, f, sv, us, ef, e_done, e_fault, e_bus, we, f3, addr);
      end
      if (!we || e_fault) begin
        checks++;
        if (r !== e_rdata) begin failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h (f3=%0d addr=%h word=%h)", i, r, e_rdata, f3, addr, word); end
      end
      if (e_acc) begin
        checks++;
        if (ac !== 1'b1 || aa !== {addr[31:2], 2'b00} || ab !== e_be || aw !== we || (we && ad !== e_wdata)) begin
          failures++;
          $display("FAIL rand_bus[%0d]: got acc=%b addr=%h be=%b we=%b wdata=%h expected 1/%h/%b/%b/%h",
                   i, ac, aa, ab, aw, ad, {addr[31:2], 2'b00}, e_be, we, e_wdata);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    core_req = 1'b0; core_we = 1'b0; core_funct3 = '0; core_addr = '0; core_wdata = '0;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core datapath's memory port (ALU result as address, store data, load result) and a handshaked data-memory bus. Accepts one access at a time, stalls the core until completion, generates byte enables and store-lane replication, and returns sign- or zero-extended load data. Flags misaligned, illegal-size, and timed-out accesses instead of issuing or hanging on them.

## Interface
- TIMEOUT, 64: max cycles waiting in REQ or RESP before abort; must be ≥ 2.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_req  in  1  access requested this cycle; held stable by core while stall=1.
- core_we  in  1  1 = store, 0 = load.
- core_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, right-aligned.
- stall  out  1  core must hold its state.
- rdata  out  32  extended load result; valid only in the DONE cycle.
- fault  out  1  one-cycle pulse in DONE: misaligned, illegal, or timeout.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted when valid & ready.
- bus_we  out  1  write request.
- bus_addr  out  32  word address, {core_addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rvalid  in  1  read data valid; ignored outside RESP.
- bus_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: if core_req, register we/funct3/addr/be/wdata. Misaligned (H with addr[0]=1, W with addr[1:0]≠0) or illegal funct3 (011, 110, 111; 100/101 with we=1) → DONE with fault, no bus activity. Otherwise → REQ.
- REQ: bus_valid=1, outputs held stable until bus_ready. On accept: write → DONE, read → RESP.
- RESP: on bus_rvalid, capture extended bus_rdata into rdata register → DONE.
- DONE: stall=0, rdata/fault presented; unconditional → IDLE. One bubble between back-to-back accesses.
- stall = core_req & (state ≠ DONE).
- Byte enables: B → 4'b0001 << addr[1:0]; H → 4'b0011 << addr[1:0]; W → 4'b1111.
- Store replication: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- Load extraction: shift bus_rdata right by 8·addr[1:0], then extend bit 7 (LB), bit 15 (LH), zero (LBU/LHU), none (LW).
- Timeout: counter cleared on entering REQ, counts in REQ and RESP; reaching TIMEOUT−1 without completion → DONE with fault, rdata=0, bus_valid dropped.
- Faulted access: rdata=0; register file write-back of 0 is the core's responsibility to suppress.
- core_req dropped mid-transaction: transaction still completes; DONE still visited; bus protocol never violated.

## Timing
- Reset (async assert, sync release): state=IDLE, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, fault=0, counter=0. stall follows core_req (combinational).
- Reset mid-transaction drops bus_valid immediately; the bus slave tolerates abandoned requests.
- Load, zero-wait bus (ready in first REQ cycle, rvalid next cycle): core_req at cycle 0; stall=1 cycles 0–2; DONE cycle 3 with rdata valid, stall=0.
- Store, zero-wait: stall=1 cycles 0–1; DONE cycle 2.
- Fault in IDLE: stall=1 cycle 0; DONE cycle 1, fault=1.
- bus_rvalid coinciding with the timeout limit: data wins, no fault.
- All bus outputs are registered; no combinational path from bus inputs to bus outputs.

## Structure
- lsu_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t.
- Sub-module lsu_align: combinational byte-enable generation, store replication, and load extract/extend; reused by later cache work.

## Test plan
- LB from addr 0x103, bus word 0x80FF_1234 → rdata 0xFFFF_FF80, fault=0, bus_be irrelevant; LBU same → 0x0000_0080.
- SH data 0x0000_ABCD to addr 0x202 → bus_be 4'b1100, bus_wdata 0xABCD_ABCD, bus_addr 0x200, DONE at cycle 2.
- LW to addr 0x006 → fault pulse at cycle 1, bus_valid never asserted, rdata 0.
- bus_ready held low 3 cycles on a load → bus_valid/bus_addr stable throughout; DONE 3 cycles later than zero-wait case.
- TIMEOUT=8, bus_rvalid never asserted → fault in DONE, rdata 0, return to IDLE, next access succeeds.
- reset_n asserted while in RESP → all outputs at reset values same cycle; fresh LW after release completes normally.
